// File: rtl/traffic_pkg.sv
// Shared light encoding, intersection phase codes and the light decode helper.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } light_t;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    PED_WALK  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALL_RED_B = 3'd6
  } phase_t;

  typedef enum logic {
    ROAD_NS = 1'b0,
    ROAD_EW = 1'b1
  } road_t;

  function automatic light_t light_of(input phase_t p, input road_t r);
    light_t l;
    l = RED;
    if (r == ROAD_NS) begin
      if (p == NS_GREEN)       l = GREEN;
      else if (p == NS_YELLOW) l = YELLOW;
    end else begin
      if (p == EW_GREEN)       l = GREEN;
      else if (p == EW_YELLOW) l = YELLOW;
    end
    return l;
  endfunction

endpackage

// File: rtl/intersection_ctrl_if.sv
// Request inputs and signal-head outputs of the intersection controller.
interface intersection_ctrl_if #(
  parameter int CW = 8
);
  logic          ew_car_req;
  logic          ped_btn;
  logic [1:0]    ns_light;
  logic [1:0]    ew_light;
  logic          walk;
  logic [2:0]    phase;
  logic [CW-1:0] time_left;

  modport master (
    input  ew_car_req, ped_btn,
    output ns_light, ew_light, walk, phase, time_left
  );

  modport slave (
    output ew_car_req, ped_btn,
    input  ns_light, ew_light, walk, phase, time_left
  );
endinterface

// File: rtl/intersection_ctrl_timer.sv
// Loadable down-counter that holds at zero; load has priority over counting.
module phase_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (load)       count <= load_val;
    else if (!zero) count <= count - 1'b1;
  end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road phase scheduler: NS main road, EW side road, pedestrian walk,
// with latched side-road and pedestrian demand and embedded safety checks.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN    = 16,
  parameter int MAX_GREEN    = 48,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 8,
  parameter int CW           = 8
) (
  input  logic                clk,
  input  logic                reset,
  intersection_ctrl_if.master bus
);

  localparam logic [CW-1:0] GREEN_LOAD  = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LOAD = CW'(YELLOW_TIME - 1);
  localparam logic [CW-1:0] AR_LOAD     = CW'(ALL_RED_TIME - 1);
  localparam logic [CW-1:0] WALK_LOAD   = CW'(WALK_TIME - 1);
  localparam logic [CW-1:0] REST_LIMIT  = CW'(MAX_GREEN - MIN_GREEN);
  localparam logic [15:0]   RESP_BOUND  =
    16'(2 * MAX_GREEN + WALK_TIME + 2 * (YELLOW_TIME + ALL_RED_TIME));

  phase_t        state, next_state;
  logic          ew_pend, ped_pend;
  logic          ew_pend_eff, ped_pend_eff;
  logic          timer_load, timer_zero;
  logic [CW-1:0] timer, timer_load_val;
  logic [15:0]   ew_wait;

  // Demand seen this cycle includes a request arriving now, so a press
  // ends a resting NS green one cycle earlier than waiting for the latch.
  assign ew_pend_eff  = ew_pend  | (bus.ew_car_req && state != EW_GREEN);
  assign ped_pend_eff = ped_pend | (bus.ped_btn    && state != PED_WALK);

  function automatic logic [CW-1:0] load_for(input phase_t p);
    logic [CW-1:0] v;
    case (p)
      NS_GREEN, EW_GREEN:   v = GREEN_LOAD;
      NS_YELLOW, EW_YELLOW: v = YELLOW_LOAD;
      PED_WALK:             v = WALK_LOAD;
      default:              v = AR_LOAD;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= ALL_RED_B;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      NS_GREEN:
        if ((ew_pend_eff || ped_pend_eff) && timer <= REST_LIMIT) next_state = NS_YELLOW;
      NS_YELLOW:
        if (timer_zero) next_state = ALL_RED_A;
      ALL_RED_A:
        if (timer_zero) next_state = ped_pend_eff ? PED_WALK : EW_GREEN;
      PED_WALK:
        if (timer_zero) next_state = ew_pend_eff ? EW_GREEN : ALL_RED_B;
      EW_GREEN:
        if (timer_zero || (!bus.ew_car_req && timer <= REST_LIMIT)) next_state = EW_YELLOW;
      EW_YELLOW:
        if (timer_zero) next_state = ALL_RED_B;
      ALL_RED_B:
        if (timer_zero) next_state = NS_GREEN;
      default:
        next_state = ALL_RED_B;
    endcase
  end

  always_comb begin
    bus.ns_light  = light_of(state, ROAD_NS);
    bus.ew_light  = light_of(state, ROAD_EW);
    bus.walk      = (state == PED_WALK);
    bus.phase     = state;
    bus.time_left = timer;
  end

  // Reset reuses the load path so the timer needs no reset of its own.
  always_comb begin
    timer_load     = reset || (next_state != state);
    timer_load_val = reset ? AR_LOAD : load_for(next_state);
  end

  phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .load     (timer_load),
    .load_val (timer_load_val),
    .count    (timer),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ew_pend  <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      ew_pend  <= (next_state == EW_GREEN && state != EW_GREEN) ? 1'b0 : ew_pend_eff;
      ped_pend <= (next_state == PED_WALK && state != PED_WALK) ? 1'b0 : ped_pend_eff;
    end
  end

  // Cycles a continuously held side-road request has waited for its green.
  always_ff @(posedge clk) begin
    if (reset || !bus.ew_car_req || state == EW_GREEN) ew_wait <= '0;
    else if (ew_wait != '1)                            ew_wait <= ew_wait + 1'b1;
  end

  a_green_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.ns_light != RED && bus.ew_light != RED));
  a_walk_red:   assert property (@(posedge clk) disable iff (reset)
    bus.walk |-> (bus.ns_light == RED && bus.ew_light == RED));
  a_light_code: assert property (@(posedge clk) disable iff (reset)
    bus.ns_light != 2'd3 && bus.ew_light != 2'd3);
  a_phase_code: assert property (@(posedge clk) disable iff (reset)
    bus.phase != 3'd7);
  a_timer_max:  assert property (@(posedge clk) disable iff (reset)
    bus.time_left <= GREEN_LOAD);
  a_ew_resp:    assert property (@(posedge clk) disable iff (reset)
    ew_wait <= RESP_BOUND);

endmodule

// File: tb/tb_intersection_ctrl.sv
// Randomised and directed bench for intersection_ctrl against a phase/elapsed-time model.
module tb_intersection_ctrl;

  localparam int MIN_G = 16;
  localparam int MAX_G = 48;
  localparam int YEL   = 4;
  localparam int AR    = 2;
  localparam int WALK  = 8;
  localparam int CW    = 8;

  logic clk = 1'b0;
  logic reset;

  intersection_ctrl_if #(.CW(CW)) bus ();

  intersection_ctrl #(
    .MIN_GREEN    (MIN_G),
    .MAX_GREEN    (MAX_G),
    .YELLOW_TIME  (YEL),
    .ALL_RED_TIME (AR),
    .WALK_TIME    (WALK),
    .CW           (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase number (0..6) and cycles spent in it so far.
  int m_ph, m_el;
  bit m_ewp, m_pedp;
  bit m_valid = 1'b0;

  int cnt_ewg, cnt_walk, first_ewg, first_walk;

  function automatic int dur_of(input int ph);
    case (ph)
      0, 4:    return MAX_G;
      1, 5:    return YEL;
      3:       return WALK;
      default: return AR;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit p);
    int  nph;
    bit  ewe, pe, done, rest_ok;
    if (r) begin
      m_valid = 1'b1; m_ph = 6; m_el = 0; m_ewp = 1'b0; m_pedp = 1'b0;
      return;
    end
    if (!m_valid) return;
    ewe     = m_ewp  || (e && m_ph != 4);
    pe      = m_pedp || (p && m_ph != 3);
    done    = (m_el >= dur_of(m_ph) - 1);
    rest_ok = (m_el >= MIN_G - 1);
    nph     = m_ph;
    case (m_ph)
      0: if ((ewe || pe) && rest_ok) nph = 1;
      1: if (done) nph = 2;
      2: if (done) nph = pe ? 3 : 4;
      3: if (done) nph = ewe ? 4 : 6;
      4: if (done || (!e && rest_ok)) nph = 5;
      5: if (done) nph = 6;
      6: if (done) nph = 0;
      default: nph = 6;
    endcase
    m_ewp  = (nph == 4 && m_ph != 4) ? 1'b0 : ewe;
    m_pedp = (nph == 3 && m_ph != 3) ? 1'b0 : pe;
    m_el   = (nph != m_ph) ? 0 : m_el + 1;
    m_ph   = nph;
  endtask

  task automatic compare_model();
    int tl, ns, ew;
    if (!m_valid) return;
    tl = dur_of(m_ph) - 1 - m_el;
    if (tl < 0) tl = 0;
    ns = (m_ph == 0) ? 1 : (m_ph == 1) ? 2 : 0;
    ew = (m_ph == 4) ? 1 : (m_ph == 5) ? 2 : 0;
    check("model_phase", int'(bus.phase), m_ph);
    check("model_ns", int'(bus.ns_light), ns);
    check("model_ew", int'(bus.ew_light), ew);
    check("model_walk", int'(bus.walk), (m_ph == 3) ? 1 : 0);
    check("model_time_left", int'(bus.time_left), tl);
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, then compare after it.
  task automatic tick(input bit r, input bit e, input bit p);
    reset = r;
    bus.ew_car_req = e;
    bus.ped_btn = p;
    model_step(r, e, p);
    @(negedge clk);
    compare_model();
  endtask

  task automatic window(input int n);
    cnt_ewg = 0; cnt_walk = 0; first_ewg = -1; first_walk = -1;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (bus.ew_light == 2'd1) begin
        cnt_ewg++;
        if (first_ewg < 0) first_ewg = i;
      end
      if (bus.walk) begin
        cnt_walk++;
        if (first_walk < 0) first_walk = i;
        check("walk_heads_red", int'(bus.ns_light) + int'(bus.ew_light), 0);
      end
    end
  endtask

  initial begin
    int  k, run;
    bit  e_rand;
    reset = 1'b1;
    bus.ew_car_req = 1'b0;
    bus.ped_btn = 1'b0;
    @(negedge clk);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check("rst_phase", int'(bus.phase), 6);
    check("rst_time_left", int'(bus.time_left), 1);
    check("rst_ns", int'(bus.ns_light), 0);
    check("rst_ew", int'(bus.ew_light), 0);
    check("rst_walk", int'(bus.walk), 0);

    // Idle after reset: NS green at cycle 2, timer reaches 0 at cycle 49 and holds.
    tick(1'b0, 1'b0, 1'b0);
    check("idle_c1_ns", int'(bus.ns_light), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("idle_c2_ns", int'(bus.ns_light), 1);
    check("idle_c2_tl", int'(bus.time_left), 47);
    repeat (46) tick(1'b0, 1'b0, 1'b0);
    check("idle_c48_tl", int'(bus.time_left), 1);
    tick(1'b0, 1'b0, 1'b0);
    check("idle_c49_tl", int'(bus.time_left), 0);
    repeat (150) tick(1'b0, 1'b0, 1'b0);
    check("idle_rest_ns", int'(bus.ns_light), 1);
    check("idle_rest_tl", int'(bus.time_left), 0);

    // Single side-road pulse: 16-cycle EW green, no walk.
    tick(1'b0, 1'b1, 1'b0);
    check("ew_pulse_yellow", int'(bus.ns_light), 2);
    window(100);
    check("ew_pulse_green_len", cnt_ewg, 16);
    check("ew_pulse_walk", cnt_walk, 0);
    check("ew_pulse_back_ns", int'(bus.ns_light), 1);

    // Pedestrian pulse: 8-cycle walk, EW never green.
    tick(1'b0, 1'b0, 1'b1);
    window(100);
    check("ped_walk_len", cnt_walk, 8);
    check("ped_ew_green", cnt_ewg, 0);

    // Both together: walk first, then EW green.
    tick(1'b0, 1'b1, 1'b1);
    window(100);
    check("both_walk_len", cnt_walk, 8);
    check("both_ew_len", cnt_ewg, 16);
    check("both_walk_first", (first_walk >= 0 && first_walk < first_ewg) ? 1 : 0, 1);
    check("both_ew_after_walk", first_ewg - first_walk, 8);

    // Side-road request held: 48-cycle EW green, 16-cycle NS green between.
    k = 0;
    while (bus.ew_light != 2'd1 && k < 200) begin tick(1'b0, 1'b1, 1'b0); k++; end
    check("hold_reach_ew", (k < 200) ? 1 : 0, 1);
    run = 0;
    while (bus.ew_light == 2'd1 && run < 300) begin tick(1'b0, 1'b1, 1'b0); run++; end
    check("hold_ew_len", run, 48);
    k = 0;
    while (bus.ns_light != 2'd1 && k < 200) begin tick(1'b0, 1'b1, 1'b0); k++; end
    check("hold_reach_ns", (k < 200) ? 1 : 0, 1);
    run = 0;
    while (bus.ns_light == 2'd1 && run < 300) begin tick(1'b0, 1'b1, 1'b0); run++; end
    check("hold_ns_len", run, 16);

    // Reset in EW green cycle 10; requests during reset are ignored.
    k = 0;
    while (bus.ew_light != 2'd1 && k < 200) begin tick(1'b0, 1'b1, 1'b0); k++; end
    check("mid_reach_ew", (k < 200) ? 1 : 0, 1);
    repeat (10) tick(1'b0, 1'b1, 1'b0);
    check("mid_ew_tl", int'(bus.time_left), 37);
    tick(1'b1, 1'b1, 1'b1);
    check("mid_rst_phase", int'(bus.phase), 6);
    check("mid_rst_tl", int'(bus.time_left), 1);
    check("mid_rst_ew", int'(bus.ew_light), 0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("mid_ns_green", int'(bus.ns_light), 1);
    repeat (60) tick(1'b0, 1'b0, 1'b0);
    check("mid_pends_clear_ns", int'(bus.ns_light), 1);

    // Randomised traffic with occasional resets.
    e_rand = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) e_rand = ~e_rand;
      tick(($urandom_range(0, 699) == 0), e_rand, ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
